// File: rtl/serial_sub_n_pkg.sv
// Purpose : shared types and the full-subtractor equations for the serial subtractor.
// Latency : n/a (types and a combinational helper only).
// Backpr. : n/a.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Single-bit full subtractor: returns {bout, d} for a - b - bin.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (bin & ~(a ^ b));
        return {bout, d};
    endfunction

endpackage

// File: rtl/serial_sub_n_full_sub_cell.sv
// Purpose : combinational one-bit full subtractor cell.
// Latency : 0 cycles (purely combinational).
// Backpr. : none; output follows inputs.
// Ports   : i_a, i_b, i_bin -> o_d (difference bit), o_bout (borrow out).
module full_sub_cell
    import sub_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic [1:0] w_res;

    assign w_res  = full_sub(i_a, i_b, i_bin);
    assign o_d    = w_res[0];
    assign o_bout = w_res[1];

endmodule

// File: rtl/serial_sub_n.sv
// Purpose : bit-serial WIDTH-bit subtractor Y = A - B - borrow_in, LSB first, one bit per clock.
// Latency : start accepted at edge k -> done high in the cycle after edge k+WIDTH; each en=0 cycle adds one.
// Backpr. : en=0 freezes every register (including busy/done); start ignored outside IDLE, no queueing.
// Ports   : clk, rst (async active-high), en, start, A, B, borrow_in in;
//           busy, done (one enabled-cycle pulse), Y, borrow_out, overflow out.
module serial_sub_n
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_y;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    full_sub_cell u_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // New difference bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
    assign w_res_next = {w_d, {(WIDTH-1){1'b0}}} | (r_res >> 1);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_y          <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh   <= A;
                        r_b_sh   <= B;
                        r_borrow <= borrow_in;
                        r_a_msb  <= A[WIDTH-1];
                        r_b_msb  <= B[WIDTH-1];
                        r_res    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    if (w_last) begin
                        // MSB step: w_d is the sign bit of the result.
                        r_y          <= w_res_next;
                        r_borrow_out <= w_bout;
                        r_overflow   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign Y          = r_y;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_sub_n.sv
module tb_serial_sub_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en8 = 1'b1, start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] Y8;

    logic       en5 = 1'b1, start5 = 1'b0, bin5 = 1'b0;
    logic [4:0] A5 = '0, B5 = '0;
    logic       busy5, done5, bo5, ov5;
    logic [4:0] Y5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub_n #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en8), .start(start8), .A(A8), .B(B8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .Y(Y8), .borrow_out(bo8), .overflow(ov8)
    );

    serial_sub_n #(.WIDTH(5)) u5 (
        .clk(clk), .rst(rst), .en(en5), .start(start5), .A(A5), .B(B5), .borrow_in(bin5),
        .busy(busy5), .done(done5), .Y(Y5), .borrow_out(bo5), .overflow(ov5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input int w, input int a, input int b, input int bi,
                                  output logic [31:0] y, output logic bo, output logic ov);
        int d, sa, sb, sd, half, full;
        full = 1 << w;
        half = 1 << (w - 1);
        d    = a - b - bi;
        y    = 32'(d & (full - 1));
        bo   = (d < 0);
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        sd   = sa - sb - bi;
        ov   = (sd < -half) || (sd > half - 1);
    endfunction

    // One operation on the 8-bit instance, optionally with random en stalls.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input bit stall, input string tag);
        int n, stalls;
        logic [31:0] ey;
        logic eb, eo;
        model(8, int'(a), int'(b), int'(bi), ey, eb, eo);
        @(negedge clk);
        A8 = a; B8 = b; bin8 = bi; start8 = 1'b1; en8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; A8 = ~a; B8 = ~b; bin8 = ~bi;
        n = 1; stalls = 0;
        while (n < 60 && !done8) begin
            if (stall) begin
                en8 = ($urandom_range(0, 3) != 0);
                if (!en8) stalls++;
            end
            @(negedge clk);
            n++;
        end
        en8 = 1'b1;
        chk({tag, "_lat"}, n, 9 + stalls);
        chk({tag, "_Y"}, Y8, ey);
        chk({tag, "_bo"}, bo8, eb);
        chk({tag, "_ov"}, ov8, eo);
        chk({tag, "_busy"}, busy8, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, done8, 0);
    endtask

    task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic bi, input string tag);
        int n;
        logic [31:0] ey;
        logic eb, eo;
        model(5, int'(a), int'(b), int'(bi), ey, eb, eo);
        @(negedge clk);
        A5 = a; B5 = b; bin5 = bi; start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        n = 1;
        while (n < 40 && !done5) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 6);
        chk({tag, "_Y"}, Y5, ey);
        chk({tag, "_bo"}, bo5, eb);
        chk({tag, "_ov"}, ov5, eo);
        @(negedge clk);
        chk({tag, "_pulse"}, done5, 0);
    endtask

    initial begin
        int n, extra;
        logic [7:0] ra, rb;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_Y", Y8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_bo", bo8, 0);
        chk("rst_ov", ov8, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived expectations
        run8(8'h35, 8'h12, 1'b0, 0, "t1");
        chk("t1_const", Y8, 8'h23);
        run8(8'h00, 8'h01, 1'b0, 0, "t2a");
        chk("t2a_const", {bo8, Y8}, 9'h1FF);
        run8(8'h05, 8'h05, 1'b1, 0, "t2b");
        run8(8'h80, 8'h01, 1'b0, 0, "t3a");
        chk("t3a_const", {ov8, bo8, Y8}, 10'h27F);
        run8(8'h7F, 8'hFF, 1'b0, 0, "t3b");
        chk("t3b_const", {ov8, bo8, Y8}, 10'h380);

        // Stall mid-RUN, a stray start during RUN, and en=0 while in DONE
        @(negedge clk);
        A8 = 8'h35; B8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; n = 1;
        repeat (2) begin @(negedge clk); n++; end
        chk("t4_Yhold", Y8, 8'h80);
        chk("t4_busy", busy8, 1);
        start8 = 1'b1; en8 = 1'b0;
        repeat (3) begin @(negedge clk); n++; end
        en8 = 1'b1;
        @(negedge clk); n++;
        start8 = 1'b0;
        while (n < 60 && !done8) begin @(negedge clk); n++; end
        chk("t4_lat", n, 12);
        chk("t4_Y", Y8, 8'h23);
        en8 = 1'b0;
        repeat (2) begin @(negedge clk); chk("t4_done_hold", done8, 1); end
        en8 = 1'b1;
        @(negedge clk);
        chk("t4_done_clr", done8, 0);
        extra = 0;
        repeat (12) begin @(negedge clk); if (done8 || busy8) extra++; end
        chk("t4_no_extra", extra, 0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        A8 = 8'h80; B8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_Y", Y8, 0);
        chk("t5_busy", busy8, 0);
        chk("t5_done", done8, 0);
        chk("t5_bo", bo8, 0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin @(negedge clk); if (done8) extra++; end
        chk("t5_no_done", extra, 0);
        run8(8'h35, 8'h12, 1'b0, 0, "t5_after");

        // Randomized operations with random stalls
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 1'($urandom), 1, "rnd8");
        end

        // Non-power-of-two width
        run5(5'h03, 5'h04, 1'b0, "t6");
        chk("t6_const", {ov5, bo5, Y5}, 7'h3F);
        for (int i = 0; i < 8; i++) begin
            run5(5'($urandom), 5'($urandom), 1'($urandom), "rnd5");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_n.md
Name: serial_sub_n

Overview:
- Parametrised bit-serial N-bit subtractor; successor to the single-bit combinational full-subtractor cell.
- Computes Y = A - B - borrow_in, LSB first, one bit per clock, using one full-subtractor cell and a borrow flip-flop.
- Start/busy/done handshake. Provides final borrow_out and signed-overflow flag.
- Used where area matters more than latency, e.g. small datapaths and teaching/demo builds in the micro-project set.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CW, $clog2(WIDTH), bit-counter width (derived localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  global enable; 0 = freeze all state (stall)
start  input  1  request new operation; sampled only in IDLE with en=1
A  input  WIDTH  minuend, captured on accepted start
B  input  WIDTH  subtrahend, captured on accepted start
borrow_in  input  1  initial borrow, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse (state DONE): Y/borrow_out/overflow valid and complete
Y  output  WIDTH  difference register
borrow_out  output  1  final borrow out of MSB
overflow  output  1  signed two's-complement overflow of A - B - borrow_in

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, operand shift regs=0, borrow FF=0.
  - Y=0, borrow_out=0, overflow=0, busy=0, done=0.
  - Reset mid-RUN aborts the operation; no done pulse.
- FSM states IDLE, RUN, DONE. All transitions are gated by en=1. With en=0, every register holds, including done and busy levels.
- IDLE:
  - start=1 at edge k captures A and B into shift regs and borrow_in into the borrow FF.
  - Clears cnt, sets state=RUN.
  - Y, borrow_out and overflow keep their previous values until the result is written.
- RUN:
  - Each enabled edge feeds the cell with a=A_sh[0], b=B_sh[0], bin=borrow FF.
  - d = a^b^bin; bout = (~a&b) | (bin&~(a^b)).
  - Shifts A_sh and B_sh right, shifts d into the result shift reg MSB, stores bout in the borrow FF, cnt+1.
  - On the edge where cnt==WIDTH-1, the completed result is loaded into Y, borrow_out=bout, overflow=(A_cap[MSB]!=B_cap[MSB]) & (d!=A_cap[MSB]), and state=DONE.
  - An MSB copy of A and B is retained for the overflow calculation.
- DONE:
  - done=1 for exactly one enabled cycle, then IDLE.
  - If en=0 in DONE, done stays high until en returns.
- start is ignored in RUN and DONE; there is no queueing.
- Latency: accept at edge k gives done=1 in the cycle after edge k+WIDTH (en held 1). Every en=0 cycle adds one cycle.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- Y is written only at completion and holds until the next completion. It is never partially updated.
- Counter never wraps. The exit compare is at WIDTH-1, so non-power-of-2 WIDTH must work (e.g. WIDTH=5).

Decomposition:
- Shared package sub_pkg:
  - state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Full-subtractor cell equations as a function usable by other blocks.
- One sub-module, full_sub_cell: combinational a, b, bin -> d, bout. Instantiated once.
- FSM, counter, shift regs and output regs stay in serial_sub_n.

Test Plan (WIDTH=8 unless stated):
1. A=0x35, B=0x12, bin=0, en=1 -> done 9 cycles after start edge; Y=0x23, borrow_out=0, overflow=0.
2. A=0x00, B=0x01, bin=0 -> Y=0xFF, borrow_out=1, overflow=0. Then A=0x05, B=0x05, bin=1 -> Y=0xFF, borrow_out=1, overflow=0.
3. A=0x80, B=0x01, bin=0 -> Y=0x7F, borrow_out=0, overflow=1. Then A=0x7F, B=0xFF -> Y=0x80, borrow_out=1, overflow=1.
4. Run of case 1 with en=0 for 3 cycles mid-RUN -> done delayed by exactly 3 cycles, Y=0x23. A second start pulse during RUN is ignored, with no extra done.
5. rst=1 asynchronously at cycle 4 of RUN -> all outputs 0 immediately, no done. Next start after release completes normally.
6. WIDTH=5: A=5'h03, B=5'h04, bin=0 -> done after 6 cycles, Y=5'h1F, borrow_out=1, overflow=0.
